// File: rtl/fft_pkg.sv
// Shared types and address helper for the radix-2 DIT butterfly scheduler.
// Address fields are sized for the largest supported transform (LOG2_N = 12);
// users truncate to their own LOG2_N.
package fft_pkg;

    localparam int MAX_LOG2_N = 12;
    localparam int MAX_AW     = MAX_LOG2_N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [MAX_AW-1:0] addr_n;
        logic [MAX_AW-1:0] addr_m;
        logic [MAX_AW-1:0] tw;
    } bfly_t;

    // Butterfly k of a stage pairs n = g*2*span + j with m = n + span, where
    // span = 2^stage, j = k mod span, g = k div span. The twiddle index is j
    // scaled up to the N/2-entry ROM.
    function automatic bfly_t bfly_addr(input int unsigned log2_n,
                                        input int unsigned stage,
                                        input int unsigned k);
        int unsigned span;
        int unsigned j;
        int unsigned g;
        int unsigned n;
        int unsigned m;
        int unsigned t;
        bfly_t       r;
        span = 32'd1 << stage;
        j    = k & (span - 32'd1);
        g    = k >> stage;
        n    = (g << (stage + 32'd1)) | j;
        m    = n + span;
        t    = j << (log2_n - 32'd1 - stage);
        r.addr_n = n[MAX_AW-1:0];
        r.addr_m = m[MAX_AW-1:0];
        r.tw     = t[MAX_AW-1:0];
        return r;
    endfunction

endpackage

// File: rtl/fft_sched_delay.sv
// Fixed-latency delay line that turns a butterfly read into its matching write.
// Runs every cycle regardless of controller state, so idle cycles travel through
// as wr_en=0 bubbles. Reset empties it so no stale write can escape an abort.
module fft_sched_delay
    import fft_pkg::*;
#(
    parameter int AW       = 4,
    parameter int PIPE_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr_n,
    input  logic [AW-1:0] in_addr_m,
    output logic          out_valid,
    output logic [AW-1:0] out_addr_n,
    output logic [AW-1:0] out_addr_m
);

    localparam int W = 1 + 2 * AW;

    logic [W-1:0] sr [PIPE_LAT];

    // Shift {valid, addr_n, addr_m} one slot per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= {in_valid, in_addr_n, in_addr_m};
            for (int i = 1; i < PIPE_LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign {out_valid, out_addr_n, out_addr_m} = sr[PIPE_LAT-1];

endmodule

// File: rtl/fft_bfly_scheduler.sv
// Butterfly issue scheduler for an in-place radix-2 DIT FFT.
// Each stage issues N/2 butterfly reads back to back, then idles PIPE_LAT cycles
// so the last write of the stage lands before the next stage's first read.
// Optional build macro FFT_SCHED_STALL_EN adds a `stall` input that holds issue
// in RUN (k and stage frozen, bubble sent down the write pipe).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one butterfly read per cycle, k = 0..N/2-1
// DRAIN | no reads, PIPE_LAT cycles for in-flight writes to land
// DONE  | one-cycle done pulse, then back to IDLE
module fft_bfly_scheduler
    import fft_pkg::*;
#(
    parameter int LOG2_N   = 4,
    parameter int PIPE_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef FFT_SCHED_STALL_EN
    input  logic              stall,
`endif
    output logic              busy,
    output logic              done,
    output logic [LOG2_N-1:0] stage,
    output logic              rd_en,
    output logic [LOG2_N-1:0] rd_addr_n,
    output logic [LOG2_N-1:0] rd_addr_m,
    output logic [LOG2_N-2:0] tw_addr,
    output logic              wr_en,
    output logic [LOG2_N-1:0] wr_addr_n,
    output logic [LOG2_N-1:0] wr_addr_m
);

    localparam int AW = LOG2_N;
    localparam int TW = LOG2_N - 1;
    localparam int KW = LOG2_N - 1;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [KW-1:0] K_LAST     = {KW{1'b1}};
    localparam logic [AW-1:0] LAST_STAGE = AW'(LOG2_N - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_LAT - 1);

    state_t        state;
    logic [KW-1:0] k_q;
    logic [DW-1:0] drain_q;
    logic          rd_en_q;
    logic          stall_i;
    logic          issue;
    logic [KW-1:0] k_nxt;
    bfly_t         nxt_k;
    bfly_t         nxt_s;

`ifdef FFT_SCHED_STALL_EN
    assign stall_i = stall;
`else
    assign stall_i = 1'b0;
`endif

    // A read is issued only while the scheduler is offering one and not held.
    assign issue = rd_en_q & ~stall_i;
    assign rd_en = issue;

    // Addresses for the next butterfly in this stage and the first of the next stage.
    assign k_nxt = k_q + 1'b1;
    assign nxt_k = bfly_addr(LOG2_N, 32'(stage), 32'(k_nxt));
    assign nxt_s = bfly_addr(LOG2_N, 32'(stage) + 32'd1, 32'd0);

    // Sequencing FSM with registered status and read-address outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k_q       <= '0;
            drain_q   <= '0;
            rd_en_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            rd_addr_n <= '0;
            rd_addr_m <= '0;
            tw_addr   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        rd_en_q   <= 1'b1;
                        k_q       <= '0;
                        stage     <= '0;
                        rd_addr_n <= '0;
                        rd_addr_m <= AW'(1);
                        tw_addr   <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (k_q == K_LAST) begin
                            state   <= DRAIN;
                            rd_en_q <= 1'b0;
                            drain_q <= DRAIN_LOAD;
                        end else begin
                            k_q       <= k_nxt;
                            rd_addr_n <= nxt_k.addr_n[AW-1:0];
                            rd_addr_m <= nxt_k.addr_m[AW-1:0];
                            tw_addr   <= nxt_k.tw[TW-1:0];
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        if (stage == LAST_STAGE) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            stage     <= '0;
                            rd_addr_n <= '0;
                            rd_addr_m <= '0;
                            tw_addr   <= '0;
                        end else begin
                            state     <= RUN;
                            stage     <= stage + 1'b1;
                            k_q       <= '0;
                            rd_en_q   <= 1'b1;
                            rd_addr_n <= nxt_s.addr_n[AW-1:0];
                            rd_addr_m <= nxt_s.addr_m[AW-1:0];
                            tw_addr   <= nxt_s.tw[TW-1:0];
                        end
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    fft_sched_delay #(
        .AW       (AW),
        .PIPE_LAT (PIPE_LAT)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (rd_en),
        .in_addr_n  (rd_addr_n),
        .in_addr_m  (rd_addr_m),
        .out_valid  (wr_en),
        .out_addr_n (wr_addr_n),
        .out_addr_m (wr_addr_m)
    );

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Directed bench for fft_bfly_scheduler, N=16, PIPE_LAT=4.
// Cycle c means the c-th clock period after the edge that samples start;
// outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_fft_bfly_scheduler;

    localparam int LOG2_N   = 4;
    localparam int PIPE_LAT = 4;
    localparam int N        = 16;
    localparam int HALF     = 8;
    localparam int SC       = HALF + PIPE_LAT;
    localparam int BUSY     = LOG2_N * SC;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
`ifdef FFT_SCHED_STALL_EN
    logic        stall;
`endif
    logic        busy;
    logic        done;
    logic [3:0]  stage;
    logic        rd_en;
    logic [3:0]  rd_addr_n;
    logic [3:0]  rd_addr_m;
    logic [2:0]  tw_addr;
    logic        wr_en;
    logic [3:0]  wr_addr_n;
    logic [3:0]  wr_addr_m;

    int checks = 0;
    int errors = 0;

    fft_bfly_scheduler #(.LOG2_N(LOG2_N), .PIPE_LAT(PIPE_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef FFT_SCHED_STALL_EN
        .stall     (stall),
`endif
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_n (rd_addr_n),
        .rd_addr_m (rd_addr_m),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_n (wr_addr_n),
        .wr_addr_m (wr_addr_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for the current cycle; returns positioned in cycle 1.
    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_stage"}, stage, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_n"}, rd_addr_n, 0);
        check({tag, "_rd_m"}, rd_addr_m, 0);
        check({tag, "_tw"}, tw_addr, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_n"}, wr_addr_n, 0);
        check({tag, "_wr_m"}, wr_addr_m, 0);
    endtask

    // Expected read issue for cycle c of an unstalled run.
    function automatic void model(input int c, output int en, output int s,
                                  output int n, output int m, output int tw);
        int r;
        int span;
        int g;
        int j;
        en = 0; s = 0; n = 0; m = 0; tw = 0;
        if (c >= 1 && c <= BUSY) begin
            s = (c - 1) / SC;
            r = (c - 1) % SC;
            if (r < HALF) begin
                en   = 1;
                span = 2 ** s;
                g    = r / span;
                j    = r % span;
                n    = g * 2 * span + j;
                m    = n + span;
                tw   = j * (N / (2 * span));
            end
        end
    endfunction

    initial begin
        int en, s, n, m, tw;
        int wen, ws, wn, wm, wtw;
        int wcount, rcount, done_cnt, done_cyc, bad_wr, bad_done, bad_busy;

        rst   = 1'b1;
        start = 1'b0;
`ifdef FFT_SCHED_STALL_EN
        stall = 1'b0;
`endif
        // Test 1: reset state
        step();
        step();
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        step();
        check("idle_busy", busy, 0);
        start = 1'b1;
        #1;
        check("no_comb_start_rd_en", rd_en, 0);

        // Test 2/3: full run trace with model and hand-computed spot checks
        step();
        start  = 1'b0;
        wcount = 0;
        rcount = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) step();
            model(c, en, s, n, m, tw);
            check("busy", busy, (c <= BUSY) ? 1 : 0);
            check("done", done, (c == BUSY + 1) ? 1 : 0);
            check("rd_en", rd_en, en);
            if (c != BUSY + 1) check("stage", stage, s);
            if (en == 1) begin
                check("rd_n", rd_addr_n, n);
                check("rd_m", rd_addr_m, m);
                check("tw", tw_addr, tw);
            end
            model(c - PIPE_LAT, wen, ws, wn, wm, wtw);
            check("wr_en", wr_en, wen);
            if (wen == 1) begin
                check("wr_n", wr_addr_n, wn);
                check("wr_m", wr_addr_m, wm);
            end
            if (wr_en === 1'b1) wcount++;
            if (rd_en === 1'b1) rcount++;
            if (c == 1) begin
                check("t2_s0k0_n", rd_addr_n, 0);
                check("t2_s0k0_m", rd_addr_m, 1);
                check("t2_s0k0_tw", tw_addr, 0);
            end
            if (c == 14) begin
                check("t2_s1k1_n", rd_addr_n, 1);
                check("t2_s1k1_m", rd_addr_m, 3);
                check("t2_s1k1_tw", tw_addr, 4);
            end
            if (c == 30) begin
                check("t2_s2k5_n", rd_addr_n, 9);
                check("t2_s2k5_m", rd_addr_m, 13);
                check("t2_s2k5_tw", tw_addr, 2);
            end
            if (c == 44) begin
                check("t2_s3k7_n", rd_addr_n, 7);
                check("t2_s3k7_m", rd_addr_m, 15);
                check("t2_s3k7_tw", tw_addr, 7);
            end
        end
        check("write_count", wcount, 32);
        check("read_count", rcount, 32);

        // Test 4: reset during stage 1 RUN
        go();
        for (int c = 2; c <= 20; c++) step();
        check("abort_pre_stage", stage, 1);
        check("abort_pre_rd_en", rd_en, 1);
        #2;
        rst = 1'b1;
        step();
        check_all_zero("abort");
        @(negedge clk);
        rst      = 1'b0;
        bad_wr   = 0;
        bad_done = 0;
        bad_busy = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (wr_en !== 1'b0) bad_wr++;
            if (done !== 1'b0) bad_done++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("abort_no_wr", bad_wr, 0);
        check("abort_no_done", bad_done, 0);
        check("abort_no_busy", bad_busy, 0);

        // Test 5: start pulses in RUN and in DONE are ignored
        go();
        done_cnt = 0;
        done_cyc = -1;
        for (int c = 1; c <= 70; c++) begin
            if (c > 1) step();
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == 51) check("ign_busy_c51", busy, 0);
            if (c == 5 || c == BUSY + 1) start = 1'b1;
            else start = 1'b0;
        end
        start = 1'b0;
        check("ign_done_count", done_cnt, 1);
        check("ign_done_cycle", done_cyc, BUSY + 1);

        // Start held high: a new run begins from IDLE after DONE
        start    = 1'b1;
        step();
        done_cyc = -1;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) step();
            if (c == 1) check("hold_first_rd_en", rd_en, 1);
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (c == BUSY + 1) check("hold_busy_done", busy, 0);
            if (c == BUSY + 2) check("hold_busy_idle", busy, 0);
            if (c == BUSY + 3) begin
                check("hold_restart_busy", busy, 1);
                check("hold_restart_rd_en", rd_en, 1);
                check("hold_restart_rd_n", rd_addr_n, 0);
                check("hold_restart_rd_m", rd_addr_m, 1);
            end
        end
        check("hold_done_cycle", done_cyc, BUSY + 1);
        start = 1'b0;
        #2;
        rst = 1'b1;
        step();
        @(negedge clk);
        rst = 1'b0;
        step();

`ifdef FFT_SCHED_STALL_EN
        // Test 6: stall for 3 cycles at stage0 k=2
        go();
        done_cyc = -1;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) step();
            stall = (c >= 3 && c <= 5) ? 1'b1 : 1'b0;
            #1;
            if (c >= 3 && c <= 5) begin
                check("stall_rd_en", rd_en, 0);
                check("stall_hold_n", rd_addr_n, 4);
            end
            if (c == 6) begin
                check("stall_resume_rd_en", rd_en, 1);
                check("stall_resume_n", rd_addr_n, 4);
                check("stall_resume_m", rd_addr_m, 5);
            end
            if (c == 6 || c == 10) check("stall_wr_live", wr_en, 1);
            if (c >= 7 && c <= 9) check("stall_wr_bubble", wr_en, 0);
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        stall = 1'b0;
        check("stall_done_cycle", done_cyc, 52);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
